// File: rtl/jogo_fluxo_dados_n_if.sv
// ---------------------------------------------------------------------------
// jogo_fluxo_dados_n_if
// Control/status bundle between the memory-game controller and its datapath.
//   slave  : datapath side (takes buttons + controls, drives flags/LEDs/debug)
//   master : controller / stimulus side
// Parameters: N_BOTOES = button/LED channels, AW = sequence address width.
// ---------------------------------------------------------------------------
interface jogo_fluxo_dados_n_if #(
    parameter int N_BOTOES = 4,
    parameter int AW       = 4
);
    logic [N_BOTOES-1:0] botoes;
    logic                zeraC, contaC, zeraCR, contaCR;
    logic                zeraTM, contaTM, zeraTempo, contaTempo;
    logic                registraR, zeraR, gravaM, ativa_leds_mem, ativa_leds_jog;

    logic                jogada_feita, jogada_correta, jogada_valida;
    logic                fimC, fimCR, enderecoIgualRodada, fimTM, meioTM, fimTempo;
    logic [N_BOTOES-1:0] leds;
    logic [AW-1:0]       db_endereco, db_rodada;
    logic [N_BOTOES-1:0] db_jogada, db_memoria;

    modport slave (
        input  botoes, zeraC, contaC, zeraCR, contaCR, zeraTM, contaTM,
               zeraTempo, contaTempo, registraR, zeraR, gravaM,
               ativa_leds_mem, ativa_leds_jog,
        output jogada_feita, jogada_correta, jogada_valida, fimC, fimCR,
               enderecoIgualRodada, fimTM, meioTM, fimTempo, leds,
               db_endereco, db_rodada, db_jogada, db_memoria
    );

    modport master (
        output botoes, zeraC, contaC, zeraCR, contaCR, zeraTM, contaTM,
               zeraTempo, contaTempo, registraR, zeraR, gravaM,
               ativa_leds_mem, ativa_leds_jog,
        input  jogada_feita, jogada_correta, jogada_valida, fimC, fimCR,
               enderecoIgualRodada, fimTM, meioTM, fimTempo, leds,
               db_endereco, db_rodada, db_jogada, db_memoria
    );
endinterface

// File: rtl/jogo_fluxo_dados_n.sv
// ---------------------------------------------------------------------------
// jogo_fluxo_dados_n
// Datapath of a "repeat the sequence" memory game: button synchronizer and
// press detector, play register, LFSR-filled sequence memory, address/round
// counters, LED display timer and an optional play timeout.
//
// Ports
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : jogo_fluxo_dados_n_if.slave -- buttons, counter/register controls
//           in; condition flags, LEDs and debug values out
//
// Optional feature: define JOGO_TIMEOUT_EN to build the play-timeout timer
// (fimTempo); without it fimTempo is tied to 0.
// ---------------------------------------------------------------------------
module jogo_fluxo_dados_n #(
    parameter int N_BOTOES   = 4,
    parameter int PROF       = 16,
    parameter int CLOCK_FREQ = 5000,
    parameter int TIMEOUT_S  = 3
) (
    input  logic                clock,
    input  logic                reset,
    jogo_fluxo_dados_n_if.slave bus
);
    localparam int AW  = $clog2(PROF);
    localparam int TMW = $clog2(CLOCK_FREQ + 1);
    localparam logic [TMW-1:0]      TM_FIM  = TMW'(CLOCK_FREQ - 1);
    localparam logic [TMW-1:0]      TM_MEIO = TMW'(CLOCK_FREQ / 2);
    localparam logic [AW-1:0]       END_FIM = AW'(PROF - 1);
    localparam logic [N_BOTOES-1:0] UM_N    = N_BOTOES'(1);

    // ---------------- button synchronizer and press detector ---------------
    logic [N_BOTOES-1:0] r_sync1, r_sync2;
    logic [1:0]          r_vld;
    logic                r_or_d, r_armado, r_feita;
    logic                w_or;

    assign w_or = |r_sync2;

    // r_vld marks when r_sync2 holds real samples after reset. r_armado only
    // rises once the synchronized buttons are seen all released, so buttons
    // held through reset release never look like a fresh press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_vld    <= '0;
            r_or_d   <= 1'b0;
            r_armado <= 1'b0;
            r_feita  <= 1'b0;
        end else begin
            r_sync1 <= bus.botoes;
            r_sync2 <= r_sync1;
            r_vld   <= {r_vld[0], 1'b1};
            r_or_d  <= w_or;
            if (r_vld[1] && !w_or) r_armado <= 1'b1;
            r_feita <= r_armado & w_or & ~r_or_d;
        end
    end

    assign bus.jogada_feita = r_feita;

    // ---------------- play register ----------------------------------------
    logic [N_BOTOES-1:0] r_jogada;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)             r_jogada <= '0;
        else if (bus.zeraR)     r_jogada <= '0;
        else if (bus.registraR) r_jogada <= r_sync2;
    end

    assign bus.jogada_valida = (r_jogada != '0) && ((r_jogada & (r_jogada - UM_N)) == '0);
    assign bus.db_jogada     = r_jogada;

    // ---------------- LFSR (x^16 + x^14 + x^13 + x^11 + 1) -----------------
    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_lfsr <= 16'hACE1;
        else        r_lfsr <= {r_lfsr[14:0], w_fb};
    end

    // ---------------- counters ---------------------------------------------
    logic [AW-1:0] r_endereco, r_rodada;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_endereco <= '0;
            r_rodada   <= '0;
        end else begin
            if (bus.zeraC)        r_endereco <= '0;
            else if (bus.contaC)  r_endereco <= r_endereco + AW'(1);
            if (bus.zeraCR)       r_rodada   <= '0;
            else if (bus.contaCR) r_rodada   <= r_rodada + AW'(1);
        end
    end

    assign bus.fimC                = (r_endereco == END_FIM);
    assign bus.fimCR               = (r_rodada == END_FIM);
    assign bus.enderecoIgualRodada = (r_endereco == r_rodada);
    assign bus.db_endereco         = r_endereco;
    assign bus.db_rodada           = r_rodada;

    // ---------------- sequence memory --------------------------------------
    // Storage has no reset so it maps onto RAM; only the read register clears.
    logic [N_BOTOES-1:0] r_mem [PROF];
    logic [N_BOTOES-1:0] r_memoria;
    logic [7:0]          w_idx;
    logic [N_BOTOES-1:0] w_onehot;

    assign w_idx    = r_lfsr[7:0] % 8'(N_BOTOES);
    assign w_onehot = UM_N << w_idx;

    always_ff @(posedge clock) begin
        if (bus.gravaM) r_mem[r_endereco] <= w_onehot;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_memoria <= '0;
        else        r_memoria <= r_mem[r_endereco];
    end

    assign bus.db_memoria     = r_memoria;
    assign bus.jogada_correta = (r_jogada == r_memoria);

    // ---------------- LED display timer ------------------------------------
    logic [TMW-1:0] r_tm;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)           r_tm <= '0;
        else if (bus.zeraTM)  r_tm <= '0;
        else if (bus.contaTM) r_tm <= (r_tm == TM_FIM) ? '0 : r_tm + TMW'(1);
    end

    assign bus.fimTM  = (r_tm == TM_FIM);
    assign bus.meioTM = (r_tm >= TM_MEIO);

    // ---------------- LED select -------------------------------------------
    always_comb begin
        bus.leds = '0;
        if (bus.ativa_leds_mem)      bus.leds = r_memoria;
        else if (bus.ativa_leds_jog) bus.leds = r_jogada;
    end

    // ---------------- play timeout -----------------------------------------
`ifdef JOGO_TIMEOUT_EN
    localparam int TO_N = TIMEOUT_S * CLOCK_FREQ;
    localparam int TOW  = $clog2(TO_N + 1);
    localparam logic [TOW-1:0] TO_FIM = TOW'(TO_N - 1);

    logic [TOW-1:0] r_tempo;
    logic           r_expirou;

    // Parks at the terminal count; r_expirou limits fimTempo to one cycle.
    // A detected press restarts the timer even while contaTempo is high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tempo   <= '0;
            r_expirou <= 1'b0;
        end else if (bus.zeraTempo || r_feita) begin
            r_tempo   <= '0;
            r_expirou <= 1'b0;
        end else begin
            if (bus.contaTempo && r_tempo != TO_FIM) r_tempo <= r_tempo + TOW'(1);
            if (r_tempo == TO_FIM)                   r_expirou <= 1'b1;
        end
    end

    assign bus.fimTempo = (r_tempo == TO_FIM) && !r_expirou;
`else
    logic w_unused_tempo;
    assign w_unused_tempo = bus.zeraTempo ^ bus.contaTempo;
    assign bus.fimTempo   = 1'b0;
`endif

endmodule

// File: tb/tb_jogo_fluxo_dados_n.sv
// ---------------------------------------------------------------------------
// tb_jogo_fluxo_dados_n
// Self-checking bench: instance A (N_BOTOES=4, PROF=16, CLOCK_FREQ=10,
// TIMEOUT_S=3) covers reset, press detection, play register, memory,
// counters, timers; instance B (N_BOTOES=8, PROF=64) covers the wide build.
// Inputs are driven 1 time unit after the rising edge and outputs sampled
// there too. An LFSR reference predicts the stored sequence words.
// ---------------------------------------------------------------------------
module tb_jogo_fluxo_dados_n;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    jogo_fluxo_dados_n_if #(.N_BOTOES(4), .AW(4)) ifa ();
    jogo_fluxo_dados_n_if #(.N_BOTOES(8), .AW(6)) ifb ();

    jogo_fluxo_dados_n #(.N_BOTOES(4), .PROF(16), .CLOCK_FREQ(10), .TIMEOUT_S(3))
        dut_a (.clock(clock), .reset(reset), .bus(ifa));
    jogo_fluxo_dados_n #(.N_BOTOES(8), .PROF(64), .CLOCK_FREQ(10), .TIMEOUT_S(3))
        dut_b (.clock(clock), .reset(reset), .bus(ifb));

    int n_tot  = 0;
    int n_pass = 0;

    // reference LFSR, x^16 + x^14 + x^13 + x^11 + 1, seed ACE1
    logic [15:0] m_lfsr;
    always @(posedge clock or negedge reset) begin
        if (!reset) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [7:0] oh(input logic [15:0] l, input int n);
        return 8'(1) << (int'(l[7:0]) % n);
    endfunction

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nome, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic idle_a();
        {ifa.zeraC, ifa.contaC, ifa.zeraCR, ifa.contaCR, ifa.zeraTM, ifa.contaTM} = '0;
        {ifa.zeraTempo, ifa.contaTempo, ifa.registraR, ifa.zeraR, ifa.gravaM} = '0;
        {ifa.ativa_leds_mem, ifa.ativa_leds_jog} = '0;
    endtask

    task automatic idle_b();
        {ifb.zeraC, ifb.contaC, ifb.zeraCR, ifb.contaCR, ifb.zeraTM, ifb.contaTM} = '0;
        {ifb.zeraTempo, ifb.contaTempo, ifb.registraR, ifb.zeraR, ifb.gravaM} = '0;
        {ifb.ativa_leds_mem, ifb.ativa_leds_jog} = '0;
    endtask

    typedef struct {
        logic [3:0] b;
        logic       reg_r;
        logic       zr;
        logic       aj;
        logic [3:0] e_jog;
        logic       e_val;
        logic [3:0] e_leds;
    } vec_t;

    vec_t tab [6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_mem [16];
        logic [7:0] t8;
        logic [3:0] novo;
        logic [7:0] exp_b;
        int         n, primeiro;

        //            botoes  regR  zeraR aj    jog      val   leds
        tab[0] = '{4'b0001, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b1, 4'b0001};
        tab[1] = '{4'b0110, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b0, 4'b0110};
        tab[2] = '{4'b1000, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, 4'b0110};
        tab[3] = '{4'b1000, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b1, 4'b0000};
        tab[4] = '{4'b0100, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000};
        tab[5] = '{4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b1, 4'b0100};

        reset = 1'b0;
        idle_a();
        idle_b();
        ifa.botoes = 4'b0010;
        ifb.botoes = '0;
        tick(3);

        // ---- reset state
        chk("rst_endereco", ifa.db_endereco, 0);
        chk("rst_rodada", ifa.db_rodada, 0);
        chk("rst_jogada", ifa.db_jogada, 0);
        chk("rst_memoria", ifa.db_memoria, 0);
        chk("rst_feita", ifa.jogada_feita, 0);
        chk("rst_igual", ifa.enderecoIgualRodada, 1);
        chk("rst_fimC", ifa.fimC, 0);
        chk("rst_fimTM", ifa.fimTM, 0);
        chk("rst_meioTM", ifa.meioTM, 0);
        chk("rst_leds", ifa.leds, 0);
        chk("rst_fimTempo", ifa.fimTempo, 0);

        // ---- release with a button held: no press pulse
        reset = 1'b1;
        n = 0;
        repeat (8) begin tick(); n += int'(ifa.jogada_feita); end
        chk("held_release_pulses", n, 0);
        ifa.botoes = 4'b0000;
        tick(4);
        ifa.botoes = 4'b0001;
        tick(); chk("press_c1", ifa.jogada_feita, 0);
        tick(); chk("press_c2", ifa.jogada_feita, 0);
        tick(); chk("press_c3", ifa.jogada_feita, 1);
        tick(); chk("press_c4", ifa.jogada_feita, 0);

        // ---- play register / valid / LED vectors
        foreach (tab[i]) begin
            ifa.botoes = tab[i].b;
            tick(2);
            ifa.registraR      = tab[i].reg_r;
            ifa.zeraR          = tab[i].zr;
            ifa.ativa_leds_jog = tab[i].aj;
            tick();
            ifa.registraR = 1'b0;
            ifa.zeraR     = 1'b0;
            chk($sformatf("vec%0d_jogada", i), ifa.db_jogada, tab[i].e_jog);
            chk($sformatf("vec%0d_valida", i), ifa.jogada_valida, tab[i].e_val);
            chk($sformatf("vec%0d_leds", i), ifa.leds, tab[i].e_leds);
        end
        idle_a();

        // ---- memory fill 0..15, then read back
        ifa.zeraC = 1'b1; tick(); ifa.zeraC = 1'b0;
        for (int a = 0; a < 16; a++) begin
            ifa.gravaM = 1'b1;
            ifa.contaC = 1'b1;
            t8 = oh(m_lfsr, 4);
            exp_mem[a] = t8[3:0];
            tick();
        end
        ifa.gravaM = 1'b0;
        chk("fill_wrap_endereco", ifa.db_endereco, 0);
        for (int a = 0; a < 16; a++) begin
            tick();
            chk($sformatf("mem_rd%0d", a), ifa.db_memoria, exp_mem[a]);
            chk($sformatf("mem_oh%0d", a), $countones(ifa.db_memoria), 1);
        end
        ifa.contaC = 1'b0;

        // ---- write and read same address in one cycle: old data first
        t8 = oh(m_lfsr, 4);
        novo = t8[3:0];
        ifa.gravaM = 1'b1;
        tick();
        ifa.gravaM = 1'b0;
        chk("rw_same_old", ifa.db_memoria, exp_mem[0]);
        exp_mem[0] = novo;
        tick();
        chk("rw_same_new", ifa.db_memoria, exp_mem[0]);

        // ---- jogada_correta
        ifa.botoes = exp_mem[0];
        tick(2); ifa.registraR = 1'b1; tick(); ifa.registraR = 1'b0;
        chk("correta_eq", ifa.jogada_correta, 1);
        chk("correta_valida", ifa.jogada_valida, 1);
        ifa.botoes = 4'b0110;
        tick(2); ifa.registraR = 1'b1; tick(); ifa.registraR = 1'b0;
        chk("correta_ne", ifa.jogada_correta, 0);
        chk("valida_two_bits", ifa.jogada_valida, 0);

        // ---- address counter
        ifa.zeraC = 1'b1; tick(); ifa.zeraC = 1'b0;
        ifa.contaC = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("cnt_end%0d", k), ifa.db_endereco, k % 16);
            chk($sformatf("cnt_fimC%0d", k), ifa.fimC, (k == 15));
        end
        tick(3);
        ifa.zeraC = 1'b1; tick(); ifa.zeraC = 1'b0;
        chk("zera_wins", ifa.db_endereco, 0);
        tick(2);
        ifa.contaC = 1'b0;
        tick(3);
        chk("cnt_hold", ifa.db_endereco, 2);

        // ---- round counter / equality
        ifa.zeraCR = 1'b1; tick(); ifa.zeraCR = 1'b0;
        ifa.contaCR = 1'b1; tick(2); ifa.contaCR = 1'b0;
        tick();
        chk("rodada_val", ifa.db_rodada, 2);
        chk("igual_eq", ifa.enderecoIgualRodada, 1);
        ifa.contaC = 1'b1; tick(); ifa.contaC = 1'b0;
        chk("igual_ne", ifa.enderecoIgualRodada, 0);

        // ---- display timer, CLOCK_FREQ = 10
        ifa.zeraTM = 1'b1; tick(); ifa.zeraTM = 1'b0;
        ifa.contaTM = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("tm_meio%0d", k), ifa.meioTM, ((k % 10) >= 5));
            chk($sformatf("tm_fim%0d", k), ifa.fimTM, ((k % 10) == 9));
        end
        tick(5);
        chk("tm_mid_meio", ifa.meioTM, 1);

        // ---- reset in the middle of a count, button held through release
        ifa.botoes = 4'b1000;
        reset = 1'b0;
        #1;
        chk("midrst_meio", ifa.meioTM, 0);
        chk("midrst_endereco", ifa.db_endereco, 0);
        chk("midrst_rodada", ifa.db_rodada, 0);
        chk("midrst_jogada", ifa.db_jogada, 0);
        idle_a();
        tick(2);
        reset = 1'b1;
        n = 0;
        repeat (8) begin tick(); n += int'(ifa.jogada_feita) + int'(ifa.fimTM) + int'(ifa.meioTM); end
        chk("midrst_no_pulses", n, 0);
        ifa.botoes = 4'b0000;
        tick(4);

        // ---- play timeout
        ifa.zeraTempo = 1'b1; tick(); ifa.zeraTempo = 1'b0;
        ifa.contaTempo = 1'b1;
`ifdef JOGO_TIMEOUT_EN
        n = 0; primeiro = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (ifa.fimTempo) begin n++; primeiro = k; end
        end
        chk("to_pulses", n, 1);
        chk("to_cycle", primeiro, 29);
        ifa.zeraTempo = 1'b1; tick(); ifa.zeraTempo = 1'b0;
        n = 0;
        for (int k = 1; k <= 50; k++) begin
            if (k == 21) ifa.botoes = 4'b0010;
            tick();
            n += int'(ifa.fimTempo);
        end
        chk("to_press_none", n, 0);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            n += int'(ifa.fimTempo);
        end
        chk("to_after_press", n, 1);
`else
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            n += int'(ifa.fimTempo);
        end
        chk("to_disabled", n, 0);
`endif
        idle_a();

        // ---- wide build: N_BOTOES = 8, PROF = 64
        ifb.zeraCR = 1'b1; tick(); ifb.zeraCR = 1'b0;
        ifb.contaCR = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k >= 62) begin
                chk($sformatf("b_rodada%0d", k), ifb.db_rodada, k % 64);
                chk($sformatf("b_fimCR%0d", k), ifb.fimCR, (k == 63));
            end
        end
        ifb.contaCR = 1'b0;
        ifb.zeraC = 1'b1; tick(); ifb.zeraC = 1'b0;
        exp_b = oh(m_lfsr, 8);
        ifb.gravaM = 1'b1; tick(); ifb.gravaM = 1'b0;
        tick();
        chk("b_mem", ifb.db_memoria, exp_b);
        ifb.botoes = 8'hA5;
        tick(2); ifb.registraR = 1'b1; tick(); ifb.registraR = 1'b0;
        ifb.ativa_leds_jog = 1'b1; tick();
        chk("b_leds_jog", ifb.leds, 8'hA5);
        ifb.ativa_leds_mem = 1'b1; tick();
        chk("b_leds_both", ifb.leds, exp_b);
        idle_b(); tick();
        chk("b_leds_off", ifb.leds, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
